// File: rtl/dcache_mem_responder.sv
// Line memory answering data-cache refill/write-back requests; ack_o pulses MEM_LATENCY+1 cycles after capture.
// One request in flight; inputs are ignored while busy. Optional protocol checker on err_o: DMEM_PROTOCOL_CHK_EN.
module dcache_mem_responder #(
   parameter int MEM_LATENCY = 10,
   parameter int LINE_IDX_W  = 9
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         enable_i,
   input  logic         write_i,
   input  logic [31:0]  addr_i,
   input  logic [255:0] data_i,
   output logic [255:0] data_o,
   output logic         ack_o,
   output logic         err_o
);
   localparam int         DEPTH    = 1 << LINE_IDX_W;
   localparam logic [7:0] CNT_LOAD = 8'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK, S_TURN} state_t;

   state_t                r_state;
   logic [7:0]            r_cnt;
   logic                  r_ack;
   logic [255:0]          r_data;
   logic [26:0]           r_addr_hi;
   logic [255:0]          r_wdata;
   logic                  r_wr;
   logic [255:0]          r_mem [DEPTH];

   logic [LINE_IDX_W-1:0] w_idx;
   logic                  w_done;
   logic                  w_mem_we;
   logic                  w_unused_ok;

   assign w_idx       = r_addr_hi[LINE_IDX_W-1:0];
   assign w_done      = (r_state == S_BUSY) && (r_cnt == 8'd0);
   assign w_mem_we    = w_done && r_wr;
   assign w_unused_ok = &{1'b0, addr_i[4:0], r_addr_hi[26:LINE_IDX_W]};

   // Storage has no reset so contents survive a reset of the control path.
   always_ff @(posedge clk_i) begin
      if (w_mem_we) begin
         r_mem[w_idx] <= r_wdata;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state   <= S_IDLE;
         r_cnt     <= 8'd0;
         r_ack     <= 1'b0;
         r_data    <= '0;
         r_addr_hi <= '0;
         r_wdata   <= '0;
         r_wr      <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (enable_i) begin
                  r_addr_hi <= addr_i[31:5];
                  r_wdata   <= data_i;
                  r_wr      <= write_i;
                  r_cnt     <= CNT_LOAD;
                  r_state   <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (r_cnt == 8'd0) begin
                  // Writes echo the stored line so data_o always shows the line just completed.
                  r_data  <= r_wr ? r_wdata : r_mem[w_idx];
                  r_ack   <= 1'b1;
                  r_state <= S_ACK;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            S_ACK:   r_state <= S_TURN;
            S_TURN:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign data_o = r_data;
   assign ack_o  = r_ack;

`ifdef DMEM_PROTOCOL_CHK_EN
   logic r_err;
   logic w_viol;

   always_comb begin
      w_viol = 1'b0;
      if (r_state == S_BUSY) begin
         if (!enable_i || (addr_i[31:5] != r_addr_hi) || (write_i != r_wr) ||
             (r_wr && (data_i != r_wdata))) begin
            w_viol = 1'b1;
         end
      end
`ifndef SYNTHESIS
      if ((r_state == S_IDLE) && enable_i && $isunknown(write_i)) begin
         w_viol = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_err <= 1'b0;
      end else if (w_viol) begin
         r_err <= 1'b1;
      end
   end

   assign err_o = r_err;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Bench for dcache_mem_responder: directed table, multi-cycle corner sequences, randomized traffic vs. line-array model.
module tb_dcache_mem_responder;
   localparam int LAT  = 10;
   localparam int IDXW = 9;

   logic         clk_i    = 1'b0;
   logic         rst_i    = 1'b0;
   logic         enable_i = 1'b0;
   logic         write_i  = 1'b0;
   logic [31:0]  addr_i   = '0;
   logic [255:0] data_i   = '0;
   logic [255:0] data_o;
   logic         ack_o;
   logic         err_o;

   always #5 clk_i = ~clk_i;

   dcache_mem_responder #(.MEM_LATENCY(LAT), .LINE_IDX_W(IDXW)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .enable_i (enable_i),
      .write_i  (write_i),
      .addr_i   (addr_i),
      .data_i   (data_i),
      .data_o   (data_o),
      .ack_o    (ack_o),
      .err_o    (err_o)
   );

   typedef struct {
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] din;
      logic [255:0] exp;
   } vec_t;

   localparam logic [255:0] DB = {8{32'hDEAD_BEEF}};
   localparam logic [255:0] P1 = {8{32'h0123_4567}};
   localparam logic [255:0] P2 = {4{64'hA5A5_5A5A_F00D_CAFE}};
   localparam logic [255:0] P3 = {8{32'h8000_0001}};
   localparam logic [255:0] P4 = {8{32'h1357_9BDF}};
   localparam logic [255:0] P5 = {8{32'h0F0F_3C3C}};

   int checks  = 0;
   int errors  = 0;
   int ack_cnt = 0;

   vec_t            vecs [11];
   logic [255:0]    mdl  [1 << IDXW];
   bit              mvld [1 << IDXW];
   logic [255:0]    dout;
   logic [255:0]    din;
   logic [31:0]     addr;
   logic [IDXW-1:0] ridx;
   logic            wr;
   bit              hold;
   bit              wig;
   int              lat;
   int              base;

   always @(negedge clk_i) begin
      if (ack_o === 1'b1) ack_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // Counts falling edges from now until ack_o is seen; n = 0 means it never came.
   task automatic wait_ack(input int limit, output int n, output logic [255:0] d);
      n = 0;
      d = '0;
      for (int c = 1; c <= limit; c++) begin
         @(negedge clk_i);
         if (ack_o === 1'b1) begin
            n = c;
            d = data_o;
            break;
         end
      end
   endtask

   // Issue one request from an idle falling edge; returns at the falling edge of the next idle cycle.
   task automatic txn(input logic t_wr, input logic [31:0] t_addr, input logic [255:0] t_din,
                      input bit t_hold, input bit t_wig, output logic [255:0] t_dout, output int t_lat);
      enable_i = 1'b1;
      write_i  = t_wr;
      addr_i   = t_addr;
      data_i   = t_din;
      @(posedge clk_i);
      if (t_wig) begin
         @(negedge clk_i);
         enable_i = 1'b0;
         addr_i   = $urandom;
         data_i   = ~t_din;
         write_i  = ~t_wr;
         wait_ack(LAT + 20, t_lat, t_dout);
         if (t_lat != 0) t_lat++;
      end else begin
         wait_ack(LAT + 20, t_lat, t_dout);
      end
      enable_i = t_hold;
      @(negedge clk_i);
      check("ack_single", 256'(ack_o), 256'(1'b0));
      enable_i = 1'b0;
      @(negedge clk_i);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 32'h0000_0040, DB,  DB};
      vecs[1]  = '{1'b0, 32'h0000_0040, '0,  DB};
      vecs[2]  = '{1'b0, 32'h0000_0044, '0,  DB};
      vecs[3]  = '{1'b1, 32'h0000_3FE0, P1,  P1};
      vecs[4]  = '{1'b0, 32'h0000_3FFF, '0,  P1};
      vecs[5]  = '{1'b1, 32'h0000_4020, P2,  P2};
      vecs[6]  = '{1'b0, 32'h0000_0020, '0,  P2};
      vecs[7]  = '{1'b1, 32'h0000_0080, P3,  P3};
      vecs[8]  = '{1'b0, 32'h0000_0080, '0,  P3};
      vecs[9]  = '{1'b1, 32'h8000_0040, P4,  P4};
      vecs[10] = '{1'b0, 32'h0000_0044, '0,  P4};

      // Reset held low for three cycles.
      repeat (3) @(negedge clk_i);
      check("reset ack_o", 256'(ack_o), 256'(1'b0));
      check("reset data_o", data_o, '0);
      check("reset err_o", 256'(err_o), 256'(1'b0));
      rst_i = 1'b1;
      @(negedge clk_i);

      for (int i = 0; i < 11; i++) begin
         txn(vecs[i].wr, vecs[i].addr, vecs[i].din, (i % 2) == 1, 1'b0, dout, lat);
         check($sformatf("vec%0d latency", i), 256'(lat), 256'(LAT + 1));
         check($sformatf("vec%0d data", i), dout, vecs[i].exp);
         check($sformatf("vec%0d data_hold", i), data_o, vecs[i].exp);
      end
      check("err after table", 256'(err_o), 256'(1'b0));

      // Write-back immediately followed by a refill with enable held high.
      base     = ack_cnt;
      enable_i = 1'b1;
      write_i  = 1'b1;
      addr_i   = 32'h0000_0440;
      data_i   = P5;
      @(posedge clk_i);
      wait_ack(LAT + 20, lat, dout);
      check("wb latency", 256'(lat), 256'(LAT + 1));
      check("wb echo", dout, P5);
      write_i = 1'b0;
      addr_i  = 32'h0000_0040;
      data_i  = '0;
      wait_ack(LAT + 20, lat, dout);
      check("refill ack distance", 256'(lat), 256'(LAT + 3));
      check("refill data", dout, P4);
      @(negedge clk_i);
      enable_i = 1'b0;
      repeat (20) @(negedge clk_i);
      check("wb+refill ack count", 256'(ack_cnt - base), 256'(2));

      // Reset during BUSY of a write: no ack, line keeps its old contents.
      base     = ack_cnt;
      enable_i = 1'b1;
      write_i  = 1'b1;
      addr_i   = 32'h0000_0080;
      data_i   = '1;
      @(posedge clk_i);
      repeat (5) @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      check("midrst ack_o", 256'(ack_o), 256'(1'b0));
      check("midrst data_o", data_o, '0);
      enable_i = 1'b0;
      write_i  = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b1;
      repeat (20) @(negedge clk_i);
      check("midrst no ack", 256'(ack_cnt - base), 256'(0));
      txn(1'b0, 32'h0000_0080, '0, 1'b0, 1'b0, dout, lat);
      check("midrst readback latency", 256'(lat), 256'(LAT + 1));
      check("midrst readback data", dout, P3);

`ifdef DMEM_PROTOCOL_CHK_EN
      check("chk err clear", 256'(err_o), 256'(1'b0));
      enable_i = 1'b1;
      write_i  = 1'b0;
      addr_i   = 32'h0000_0040;
      @(posedge clk_i);
      repeat (2) @(negedge clk_i);
      addr_i = 32'h0000_0060;
      @(negedge clk_i);
      check("chk err set", 256'(err_o), 256'(1'b1));
      wait_ack(LAT + 20, lat, dout);
      check("chk ack distance", 256'(lat), 256'(LAT + 1 - 3));
      check("chk data original addr", dout, P4);
      check("chk err sticky", 256'(err_o), 256'(1'b1));
      enable_i = 1'b0;
      repeat (2) @(negedge clk_i);
`endif

      // Randomized traffic over a few lines, with aliasing through the ignored address bits.
      for (int i = 0; i < 60; i++) begin
         ridx             = IDXW'($urandom_range(0, 7));
         addr             = $urandom;
         addr[IDXW+4:5]   = ridx;
         wr               = 1'($urandom_range(0, 1));
         for (int w = 0; w < 8; w++) din[w*32 +: 32] = $urandom;
         hold             = 1'($urandom_range(0, 1));
`ifdef DMEM_PROTOCOL_CHK_EN
         wig              = 1'b0;
`else
         wig              = ($urandom_range(0, 3) == 0);
`endif
         txn(wr, addr, din, hold, wig, dout, lat);
         check($sformatf("rand%0d latency", i), 256'(lat), 256'(LAT + 1));
         if (wr) begin
            mdl[ridx]  = din;
            mvld[ridx] = 1'b1;
            check($sformatf("rand%0d write echo", i), dout, din);
         end else if (mvld[ridx]) begin
            check($sformatf("rand%0d read data", i), dout, mdl[ridx]);
         end
      end

`ifdef DMEM_PROTOCOL_CHK_EN
      check("final err sticky", 256'(err_o), 256'(1'b1));
`else
      check("final err tied low", 256'(err_o), 256'(1'b0));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
